// File: rtl/filter_seq_ctrl.sv
// Sequencer for a shaping filter: flushes the filter delay lines, waits for it to settle,
// then qualifies its output. Holds the filter's k/l/m1/m2 configuration registers.
module filter_seq_ctrl #(
  parameter int unsigned SIZE_FILTER_DATA = 16,
  parameter int unsigned K_MAX            = 63,
  parameter int unsigned L_MAX            = 63,
  parameter int unsigned FILT_LAT         = 5,
  parameter int unsigned CLR_PAD          = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cfg_we,
  input  logic [1:0]                         cfg_addr,
  input  logic [15:0]                        cfg_wdata,
  output logic                               cfg_err,
  input  logic                               start,
  input  logic                               stop,
  input  logic signed [SIZE_FILTER_DATA-1:0] adc_data,
  output logic                               filt_rst_n,
  output logic signed [SIZE_FILTER_DATA-1:0] filt_in,
  input  logic signed [SIZE_FILTER_DATA-1:0] filt_out,
  output logic [15:0]                        k_o,
  output logic [15:0]                        l_o,
  output logic [15:0]                        m1_o,
  output logic [15:0]                        m2_o,
  output logic signed [SIZE_FILTER_DATA-1:0] data_out,
  output logic                               data_valid,
  output logic                               sat_flag,
  output logic [2:0]                         state_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StClear  = 2'd1,
    StSettle = 2'd2,
    StRun    = 2'd3
  } state_e;

  localparam logic [15:0] KMaxW    = 16'(K_MAX);
  localparam logic [15:0] LMaxW    = 16'(L_MAX);
  localparam logic [7:0]  ClrPadW  = 8'(CLR_PAD);
  localparam logic [7:0]  FiltLatW = 8'(FILT_LAT);
  localparam logic signed [SIZE_FILTER_DATA-1:0] SatMax = {1'b0, {(SIZE_FILTER_DATA-1){1'b1}}};
  localparam logic signed [SIZE_FILTER_DATA-1:0] SatMin = {1'b1, {(SIZE_FILTER_DATA-1){1'b0}}};

  state_e                        state_q, state_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic [15:0]                   k_q, k_d, l_q, l_d, m1_q, m1_d, m2_q, m2_d;
  logic                          cfg_err_q, cfg_err_d;
  logic                          valid_q, valid_d;
  logic signed [SIZE_FILTER_DATA-1:0] dout_q, dout_d;
  logic                          sat_q, sat_d;
  logic                          start_acc;
  logic [7:0]                    clr_load, settle_load;

  assign start_acc = (state_q == StIdle) && start && !stop;

  // The clear length uses the configuration that will be in force for the whole run,
  // including a write accepted on the same edge as start.
  assign clr_load    = k_d[7:0] + l_d[7:0] + ClrPadW - 8'd1;
  assign settle_load = k_q[7:0] + l_q[7:0] + FiltLatW - 8'd1;

  always_comb begin
    k_d       = k_q;
    l_d       = l_q;
    m1_d      = m1_q;
    m2_d      = m2_q;
    cfg_err_d = 1'b0;
    if (cfg_we) begin
      if (state_q != StIdle) begin
        cfg_err_d = 1'b1;
      end else begin
        case (cfg_addr)
          2'd0: if (cfg_wdata != 16'd0 && cfg_wdata <= KMaxW) k_d = cfg_wdata;
                else cfg_err_d = 1'b1;
          2'd1: if (cfg_wdata <= LMaxW) l_d = cfg_wdata;
                else cfg_err_d = 1'b1;
          2'd2: m1_d = cfg_wdata;
          2'd3: m2_d = cfg_wdata;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
    case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (start_acc) begin
          state_d = StClear;
          cnt_d   = clr_load;
        end
      end
      StClear: begin
        if (stop) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd0) begin
          state_d = StSettle;
          cnt_d   = settle_load;
        end
      end
      StSettle: begin
        if (stop) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd0) begin
          state_d = StRun;
          cnt_d   = 8'd0;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end
      end
    endcase
  end

  always_comb begin
    valid_d = (state_q == StRun) && !stop;
    dout_d  = (state_q == StRun) ? filt_out : '0;
    sat_d   = sat_q;
    if (start_acc) begin
      sat_d = 1'b0;
    end else if (state_q == StRun && (filt_out == SatMax || filt_out == SatMin)) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      k_q       <= 16'd32;
      l_q       <= 16'd16;
      m1_q      <= 16'd16;
      m2_q      <= 16'd1;
      cfg_err_q <= 1'b0;
      valid_q   <= 1'b0;
      dout_q    <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      l_q       <= l_d;
      m1_q      <= m1_d;
      m2_q      <= m2_d;
      cfg_err_q <= cfg_err_d;
      valid_q   <= valid_d;
      dout_q    <= dout_d;
      sat_q     <= sat_d;
    end
  end

  assign filt_rst_n = (state_q == StSettle) || (state_q == StRun);
  assign filt_in    = filt_rst_n ? adc_data : '0;
  assign state_o    = {1'b0, state_q};
  assign k_o        = k_q;
  assign l_o        = l_q;
  assign m1_o       = m1_q;
  assign m2_o       = m2_q;
  assign cfg_err    = cfg_err_q;
  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Bench for filter_seq_ctrl: directed scenarios then random traffic, all checked each cycle
// against a model that derives the expected state from cycles elapsed since start.
module tb_filter_seq_ctrl;

  localparam int W        = 16;
  localparam int CLR_PAD  = 4;
  localparam int FILT_LAT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, cfg_we, cfg_err, start, stop;
  logic [1:0]          cfg_addr;
  logic [15:0]         cfg_wdata;
  logic signed [W-1:0] adc_data, filt_in, filt_out, data_out;
  logic                filt_rst_n, data_valid, sat_flag;
  logic [15:0]         k_o, l_o, m1_o, m2_o;
  logic [2:0]          state_o;

  filter_seq_ctrl #(
    .SIZE_FILTER_DATA(W),
    .K_MAX(63),
    .L_MAX(63),
    .FILT_LAT(FILT_LAT),
    .CLR_PAD(CLR_PAD)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err),
    .start(start),
    .stop(stop),
    .adc_data(adc_data),
    .filt_rst_n(filt_rst_n),
    .filt_in(filt_in),
    .filt_out(filt_out),
    .k_o(k_o),
    .l_o(l_o),
    .m1_o(m1_o),
    .m2_o(m2_o),
    .data_out(data_out),
    .data_valid(data_valid),
    .sat_flag(sat_flag),
    .state_o(state_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a run is "active" with el = cycles since the accepting edge.
  int                  cfg [4];
  bit                  active;
  int                  el;
  bit                  m_err, m_valid, m_sat;
  logic [W-1:0]        m_dout;

  function automatic int exp_state();
    int c, s;
    if (!active) return 0;
    c = cfg[0] + cfg[1] + CLR_PAD;
    s = cfg[0] + cfg[1] + FILT_LAT;
    if (el <= c) return 1;
    if (el <= c + s) return 2;
    return 3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    int cur;
    cur = exp_state();
    check_eq("state_o", 32'(state_o), 32'(cur));
    check_eq("filt_rst_n", 32'(filt_rst_n), 32'(cur >= 2));
    check_eq("filt_in", {16'd0, filt_in}, (cur >= 2) ? {16'd0, adc_data} : 32'd0);
    check_eq("k_o", 32'(k_o), 32'(cfg[0]));
    check_eq("l_o", 32'(l_o), 32'(cfg[1]));
    check_eq("m1_o", 32'(m1_o), 32'(cfg[2]));
    check_eq("m2_o", 32'(m2_o), 32'(cfg[3]));
    check_eq("cfg_err", 32'(cfg_err), 32'(m_err));
    check_eq("data_valid", 32'(data_valid), 32'(m_valid));
    check_eq("data_out", {16'd0, data_out}, {16'd0, m_dout});
    check_eq("sat_flag", 32'(sat_flag), 32'(m_sat));
  endtask

  task automatic model_update();
    int cur;
    bit ok;
    if (reset) begin
      cfg[0] = 32; cfg[1] = 16; cfg[2] = 16; cfg[3] = 1;
      active = 0; el = 0;
      m_err = 0; m_valid = 0; m_sat = 0; m_dout = '0;
      return;
    end
    cur = exp_state();
    if (cfg_addr == 2'd0)      ok = (cfg_wdata >= 1) && (cfg_wdata <= 63);
    else if (cfg_addr == 2'd1) ok = (cfg_wdata <= 63);
    else                       ok = 1;
    ok = ok && (cur == 0);
    m_err = cfg_we && !ok;
    if (cfg_we && ok) cfg[cfg_addr] = int'(cfg_wdata);
    m_valid = (cur == 3) && !stop;
    m_dout  = (cur == 3) ? filt_out : '0;
    if (cur == 0 && start && !stop) m_sat = 0;
    else if (cur == 3 && (filt_out == 16'h7FFF || filt_out == 16'h8000)) m_sat = 1;
    if (cur == 0) begin
      if (start && !stop) begin
        active = 1;
        el     = 1;
      end
    end else if (stop) begin
      active = 0;
    end else begin
      el++;
    end
  endtask

  // Inputs are applied at the falling edge; outputs are checked just after.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_in();
    reset     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = 2'd0;
    cfg_wdata = 16'd0;
    start     = 1'b0;
    stop      = 1'b0;
    adc_data  = W'($urandom);
    filt_out  = W'($urandom_range(0, 1000));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) begin
      idle_in();
      step();
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [15:0] data);
    idle_in();
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    step();
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    @(posedge clk);
    model_update();
    @(negedge clk);
    idle_in();
    reset = 1'b1;
    step();
    idle_steps(1);

    // Normal run with k=8, l=4, plus rejected k=0 in IDLE
    wr(2'd0, 16'd8);
    wr(2'd1, 16'd4);
    wr(2'd0, 16'd0);
    idle_steps(1);
    idle_in(); start = 1'b1; step();
    idle_steps(40);
    wr(2'd3, 16'd3);
    idle_steps(2);
    idle_in(); filt_out = 16'h7FFF; step();
    idle_steps(3);
    idle_in(); stop = 1'b1; step();
    idle_steps(1);

    // Start/stop collision, then abort at the 5th CLEAR cycle and restart
    idle_in(); start = 1'b1; stop = 1'b1; step();
    idle_steps(1);
    idle_in(); start = 1'b1; step();
    idle_steps(4);
    idle_in(); stop = 1'b1; step();
    idle_steps(1);
    idle_in(); start = 1'b1; step();
    idle_steps(40);
    idle_in(); filt_out = 16'h8000; step();
    idle_steps(2);
    idle_in(); reset = 1'b1; start = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd2; step();
    idle_steps(2);

    // Random traffic
    for (int i = 0; i < 5000; i++) begin
      idle_in();
      adc_data  = W'($urandom);
      filt_out  = ($urandom_range(0, 63) == 0) ?
                  (($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000) : W'($urandom);
      reset     = ($urandom_range(0, 999) == 0);
      start     = ($urandom_range(0, 3) == 0);
      stop      = ($urandom_range(0, 249) == 0);
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_addr  = 2'($urandom);
      cfg_wdata = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 70));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/filter_seq_ctrl.md
FILTER_SEQ_CTRL -- requirements
Module: filter_seq_ctrl

Interface
REQ-001 Parameter SIZE_FILTER_DATA, default 16: data width of filter samples.
REQ-002 Parameter K_MAX, default 63: largest permitted k.
REQ-003 Parameter L_MAX, default 63: largest permitted l.
REQ-004 Parameter FILT_LAT, default 5: pipeline latency of the shaping filter, in clocks.
REQ-005 Parameter CLR_PAD, default 4: extra clear cycles beyond k+l.
REQ-006 clk  in  1: single clock; all logic is rising-edge.
REQ-007 reset  in  1: synchronous, active-high reset.
REQ-008 cfg_we  in  1: configuration write strobe.
REQ-009 cfg_addr  in  2: register select; 0=k, 1=l, 2=m1, 3=m2.
REQ-010 cfg_wdata  in  16: unsigned write data.
REQ-011 cfg_err  out  1: one-cycle pulse when a write is rejected.
REQ-012 start  in  1: begin a filter run.
REQ-013 stop  in  1: abort or end a run.
REQ-014 adc_data  in  SIZE_FILTER_DATA signed: raw sample, one per clock.
REQ-015 filt_rst_n  out  1: active-low reset to the filter.
REQ-016 filt_in  out  SIZE_FILTER_DATA signed: filter input.
REQ-017 filt_out  in  SIZE_FILTER_DATA signed: filter output.
REQ-018 k_o, l_o, m1_o, m2_o  out  16 each: current configuration values driven to the filter.
REQ-019 data_out  out  SIZE_FILTER_DATA signed: qualified filter output.
REQ-020 data_valid  out  1: high while data_out is valid.
REQ-021 sat_flag  out  1: sticky flag, set when filt_out reaches full scale.
REQ-022 state_o  out  3: encoded FSM state; IDLE=0, CLEAR=1, SETTLE=2, RUN=3.

Function
REQ-023 The FSM SHALL have four states: IDLE, CLEAR, SETTLE, RUN.
REQ-024 IDLE: filt_rst_n=0, filt_in=0, data_valid=0; start=1 -> CLEAR on the next cycle.
REQ-025 CLEAR: filt_rst_n=0, filt_in=0 for exactly k+l+CLR_PAD cycles, flushing the unreset delay lines with zeros; then -> SETTLE.
REQ-026 SETTLE: filt_rst_n=1, filt_in=adc_data, data_valid=0 for exactly k+l+FILT_LAT cycles; then -> RUN.
REQ-027 RUN: filt_rst_n=1, filt_in=adc_data; data_out and data_valid are registered and lag filt_out by one cycle, with data_valid=1 from the second RUN cycle onward.
REQ-028 filt_rst_n, filt_in and state_o SHALL be decoded combinationally from the state register.
REQ-029 stop=1 in CLEAR, SETTLE or RUN -> IDLE on the next cycle; data_valid SHALL be 0 in that cycle.
REQ-030 start and stop asserted together: stop wins; from IDLE the FSM stays in IDLE.
REQ-031 start outside IDLE SHALL be ignored.
REQ-032 The duration counter SHALL be 8 bits wide, load on state entry, and decrement to 0; the state advances when the counter reads 0.
REQ-033 Writes SHALL be accepted only in IDLE; a write in any other state is rejected.
REQ-034 Write validity: k in 1..K_MAX; l in 0..L_MAX; m1 and m2 accept any value.
REQ-035 A rejected write SHALL leave its register unchanged and pulse cfg_err high on the following cycle.
REQ-036 k_o, l_o, m1_o, m2_o SHALL be direct register outputs, stable throughout CLEAR, SETTLE and RUN.
REQ-037 sat_flag SHALL set in RUN when filt_out equals the maximum or minimum signed value, and SHALL clear on start accepted from IDLE.

Reset
REQ-038 On reset=1 at a clock edge, the block SHALL enter IDLE and drive data_out=0, data_valid=0, cfg_err=0, sat_flag=0, counter=0.
REQ-039 Reset SHALL load k=32, l=16, m1=16, m2=1.
REQ-040 Reset SHALL take priority over start, stop and cfg_we in the same cycle, including when asserted mid-run.

Verification
REQ-041 Reset test: assert reset for 2 cycles -> state_o=0, filt_rst_n=0, k_o=32, l_o=16, m1_o=16, m2_o=1, data_valid=0.
REQ-042 Normal run: write k=8, l=4, then pulse start at cycle 0 -> CLEAR for cycles 1-16, SETTLE for cycles 17-33, RUN from cycle 34, first data_valid=1 at cycle 35.
REQ-043 Rejected writes: write k=0 in IDLE -> cfg_err pulse, k_o unchanged; write m2=3 in RUN -> cfg_err pulse, m2_o unchanged.
REQ-044 Abort: stop at the 5th cycle of CLEAR -> IDLE next cycle, filt_rst_n=0; a subsequent start restarts the full CLEAR.
REQ-045 Start/stop collision: start and stop together in IDLE -> FSM remains in IDLE; reset asserted in RUN -> IDLE with data_valid=0 next cycle.
REQ-046 Saturation: force filt_out=16'h7FFF for 1 cycle in RUN -> sat_flag=1 and held; next accepted start -> sat_flag=0.
